// File: rtl/modulo_varredura_pkg.sv
// Shared definitions for the display scan controller: FSM state encoding,
// post-reset timing defaults and the digit one-hot encoder.
package modulo_varredura_pkg;

  localparam int MAX_NDIG     = 8;
  localparam int DEF_PERIOD_C = 50000;
  localparam int DEF_BLANK_C  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  function automatic logic [MAX_NDIG-1:0] onehot(input logic [2:0] idx);
    return MAX_NDIG'(1) << idx;
  endfunction

endpackage

// File: rtl/modulo_controle_varredura_if.sv
// Timing-configuration handshake between a host (master) and the scan
// controller (slave); a transfer happens on cfg_valid && cfg_ready.
interface modulo_controle_varredura_if #(
  parameter int PW = 20,
  parameter int BW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_period;
  logic [BW-1:0] cfg_blank;

  modport master (output cfg_valid, cfg_period, cfg_blank, input cfg_ready);
  modport slave  (input cfg_valid, cfg_period, cfg_blank, output cfg_ready);
endinterface

// File: rtl/modulo_contador_carga.sv
// Loadable synchronous down-counter with a zero flag; load wins over count
// and the value never wraps below zero.
module modulo_contador_carga #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d takes a default before any branch so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (en && !zero)      cnt_d = cnt_q - W'(1);
  end

  // NOTE: flops use <= so every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/modulo_controle_varredura.sv
// Round-robin 7-segment scan controller with runtime timing reconfiguration.
// Optional digit skipping is built when SCAN_MASK_EN is defined.
module modulo_controle_varredura
  import modulo_varredura_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int PW         = 20,
  parameter int BW         = 8,
  parameter int DEF_PERIOD = DEF_PERIOD_C,
  parameter int DEF_BLANK  = DEF_BLANK_C
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
`ifdef SCAN_MASK_EN
  input  logic [NDIG-1:0]         digit_mask,
`endif
  modulo_controle_varredura_if.slave cfg,
  output logic [$clog2(NDIG)-1:0] digit_sel,
  output logic [NDIG-1:0]         digit_en,
  output logic                    tick,
  output logic                    busy
);
  localparam int SW = $clog2(NDIG);

  scan_state_e         state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d, next_sel;
  logic [NDIG-1:0]     den_q, den_d, mask;
  logic                tick_q, tick_d, busy_q, busy_d;
  logic [PW-1:0]       period_q, period_d, shadow_p_q, shadow_p_d, eff_period;
  logic [BW-1:0]       blank_q, blank_d, shadow_b_q, shadow_b_d;
  logic                pending_q, pending_d;
  logic                cnt_load, cnt_en, cnt_zero, enter_on, scan_on;
  logic [PW-1:0]       cnt_load_val;
  logic [MAX_NDIG-1:0] oh;

`ifdef SCAN_MASK_EN
  assign mask = digit_mask;
`else
  assign mask = '1;
`endif
  assign scan_on = en && (|mask);

  // Nearest enabled digit after cur (with wrap); keep_cur lets cur itself win first.
  function automatic logic [SW-1:0] pick_digit(input logic [SW-1:0] cur,
                                               input logic [NDIG-1:0] m,
                                               input logic keep_cur);
    logic [SW-1:0] r, idx;
    r = cur;
    for (int k = NDIG - 1; k >= 1; k--) begin
      idx = SW'((int'(cur) + k) % NDIG);
      if (m[idx]) r = idx;
    end
    if (keep_cur && m[cur]) r = cur;
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    den_d        = den_q;
    tick_d       = 1'b0;
    period_d     = period_q;
    blank_d      = blank_q;
    shadow_p_d   = shadow_p_q;
    shadow_b_d   = shadow_b_q;
    pending_d    = pending_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    enter_on     = 1'b0;
    next_sel     = sel_q;
    oh           = '0;
    eff_period   = pending_q ? shadow_p_q : period_q;

    if (!scan_on) begin
      state_d = ST_IDLE;
      den_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          enter_on = 1'b1;
          next_sel = pick_digit(sel_q, mask, 1'b1);
        end
        ST_ON: if (cnt_zero) begin
          if (blank_q != '0) begin
            state_d      = ST_BLANK;
            den_d        = '0;
            cnt_load     = 1'b1;
            cnt_load_val = PW'(blank_q - BW'(1));
          end else begin
            enter_on = 1'b1;
            next_sel = pick_digit(sel_q, mask, 1'b0);
          end
        end
        ST_BLANK: if (cnt_zero) begin
          enter_on = 1'b1;
          next_sel = pick_digit(sel_q, mask, 1'b0);
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Shadow timing lands on a digit boundary, or immediately while idle.
    if (pending_q && (enter_on || state_q == ST_IDLE)) begin
      period_d  = shadow_p_q;
      blank_d   = shadow_b_q;
      pending_d = 1'b0;
    end

    if (enter_on) begin
      state_d      = ST_ON;
      sel_d        = next_sel;
      oh           = onehot(3'(next_sel));
      den_d        = oh[NDIG-1:0];
      tick_d       = 1'b1;
      cnt_load     = 1'b1;
      cnt_load_val = (eff_period == '0) ? '0 : eff_period - PW'(1);
    end

    if (cfg.cfg_valid && !pending_q) begin
      shadow_p_d = cfg.cfg_period;
      shadow_b_d = cfg.cfg_blank;
      pending_d  = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign cnt_en = (state_q != ST_IDLE);

  modulo_contador_carga #(.W(PW)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      den_q      <= '0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      period_q   <= PW'(DEF_PERIOD);
      blank_q    <= BW'(DEF_BLANK);
      shadow_p_q <= '0;
      shadow_b_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      den_q      <= den_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      period_q   <= period_d;
      blank_q    <= blank_d;
      shadow_p_q <= shadow_p_d;
      shadow_b_q <= shadow_b_d;
      pending_q  <= pending_d;
    end
  end

  assign digit_sel     = sel_q;
  assign digit_en      = den_q;
  assign tick          = tick_q;
  assign busy          = busy_q;
  assign cfg.cfg_ready = !pending_q;

endmodule

// File: tb/tb_modulo_controle_varredura.sv
// Self-checking bench for the scan controller: a slot-position reference model
// compared every cycle, pinned by hand-computed directed sequences.
module tb_modulo_controle_varredura;
  localparam int NDIG = 4;
  localparam int PW   = 20;
  localparam int BW   = 8;

  logic            clk = 1'b0;
  logic            clr, en;
  logic [NDIG-1:0] mask;
  logic [1:0]      digit_sel;
  logic [NDIG-1:0] digit_en;
  logic            tick, busy;
  bit              chk_on = 1'b0;
  int              n_assert = 0;
  int              n_fail = 0;

  modulo_controle_varredura_if #(.PW(PW), .BW(BW)) cfg_if ();

  modulo_controle_varredura #(.NDIG(NDIG), .PW(PW), .BW(BW)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
`ifdef SCAN_MASK_EN
    .digit_mask(mask),
`endif
    .cfg       (cfg_if),
    .digit_sel (digit_sel),
    .digit_en  (digit_en),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the current digit slot of length P+B.
  int m_sel, m_pos, m_preg, m_breg, m_shp, m_shb;
  bit m_act, m_pend;

  function automatic int m_plen();
    return (m_preg == 0) ? 1 : m_preg;
  endfunction

  function automatic int m_pick(input int from, input bit include_cur);
    logic [1:0] ix;
    for (int k = include_cur ? 0 : 1; k <= NDIG; k++) begin
      ix = 2'((from + k) % NDIG);
      if (mask[ix]) return (from + k) % NDIG;
    end
    return from;
  endfunction

  task automatic m_copy();
    m_preg = m_shp;
    m_breg = m_shb;
    m_pend = 1'b0;
  endtask

  always @(posedge clk) begin
    bit xfer, ena;
    xfer = cfg_if.cfg_valid && !m_pend;
    ena  = en && (mask != '0);
    if (clr) begin
      m_act = 0; m_pos = 0; m_sel = 0; m_pend = 0;
      m_preg = 50000; m_breg = 16; m_shp = 0; m_shb = 0;
    end else begin
      if (!ena) begin
        if (!m_act && m_pend) m_copy();
        m_act = 0;
      end else if (!m_act) begin
        if (m_pend) m_copy();
        m_sel = m_pick(m_sel, 1'b1);
        m_pos = 0;
        m_act = 1;
      end else begin
        m_pos++;
        if (m_pos >= m_plen() + m_breg) begin
          m_sel = m_pick(m_sel, 1'b0);
          if (m_pend) m_copy();
          m_pos = 0;
        end
      end
      if (xfer) begin
        m_shp  = int'(cfg_if.cfg_period);
        m_shb  = int'(cfg_if.cfg_blank);
        m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int eden;
      eden = (m_act && m_pos < m_plen()) ? (1 << m_sel) : 0;
      check("cmp_digit_en",  32'(digit_en),  eden);
      check("cmp_tick",      32'(tick),      (m_act && m_pos == 0) ? 1 : 0);
      check("cmp_busy",      32'(busy),      m_act ? 1 : 0);
      check("cmp_digit_sel", 32'(digit_sel), m_sel);
      check("cmp_cfg_ready", 32'(cfg_if.cfg_ready), m_pend ? 0 : 1);
    end
  end

  task automatic cfg_idle(input int p, input int b);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = PW'(p);
    cfg_if.cfg_blank  = BW'(b);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic trace(input string nm, input int den[$], input int tk[$]);
    foreach (den[i]) begin
      @(negedge clk);
      check($sformatf("%s_den%0d", nm, i), 32'(digit_en), den[i]);
      check($sformatf("%s_tick%0d", nm, i), 32'(tick), tk[i]);
    end
  endtask

  task automatic wait_den(input string nm, input int pat);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (32'(digit_en) == pat) ok = 1'b1;
    end
    check({nm, "_reached"}, 32'(ok), 1);
  endtask

  initial begin
    int q_den[$], q_tick[$], q_rdy[$];
    bit ok;

    clr = 1'b1; en = 1'b1; mask = '1;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = PW'(7); cfg_if.cfg_blank = BW'(3);
    repeat (2) @(negedge clk);
    check("rst_digit_en",  32'(digit_en), 0);
    check("rst_tick",      32'(tick), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
    check("rst_digit_sel", 32'(digit_sel), 0);
    check("rst_period",    32'(dut.period_q), 50000);
    check("rst_blank",     32'(dut.blank_q), 16);
    clr = 1'b0; en = 1'b0; cfg_if.cfg_valid = 1'b0;
    chk_on = 1'b1;

    // Basic scan P=3 B=1
    cfg_idle(3, 1);
    check("idle_copy_ready", 32'(cfg_if.cfg_ready), 1);
    en = 1'b1;
    q_den  = '{1,1,1,0, 2,2,2,0, 4,4,4,0, 8,8,8,0, 1};
    q_tick = '{1,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0, 1};
    trace("basic", q_den, q_tick);
    en = 1'b0;
    @(negedge clk);
    check("basic_stop_den",  32'(digit_en), 0);
    check("basic_stop_busy", 32'(busy), 0);
    check("basic_stop_sel",  32'(digit_sel), 0);

    // No blanking P=2 B=0
    cfg_idle(2, 0);
    en = 1'b1;
    q_den  = '{1,1,2,2,4,4,8,8,1};
    q_tick = '{1,0,1,0,1,0,1,0,1};
    trace("noblank", q_den, q_tick);
    en = 1'b0;
    @(negedge clk);

    // Mid-scan reconfiguration: P=5 offered at the start of digit 1
    cfg_idle(3, 1);
    en = 1'b1;
    wait_den("recfg", 2);
    q_den = '{2,2,2,0, 4,4,4,4,4,0, 8,8,8,8,8,0};
    q_rdy = '{1,0,0,0, 1,1,1,1,1,1, 1,1,1,1,1,1};
    for (int r = 0; r < 16; r++) begin
      if (r > 0) @(negedge clk);
      check($sformatf("recfg_den%0d", r), 32'(digit_en), q_den[r]);
      check($sformatf("recfg_rdy%0d", r), 32'(cfg_if.cfg_ready), q_rdy[r]);
      case (r)
        0: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = PW'(5); cfg_if.cfg_blank = BW'(1); end
        1: begin cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = PW'(7); cfg_if.cfg_blank = BW'(1); end
        3: cfg_if.cfg_valid = 1'b0;
        default: ;
      endcase
    end

    // Abort mid-ON on digit 2
    wait_den("abort", 4);
    en = 1'b0;
    @(negedge clk);
    check("abort_den",  32'(digit_en), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_tick", 32'(tick), 0);
    check("abort_sel",  32'(digit_sel), 2);

    // Reset while blanking
    en = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (busy && digit_en == '0) ok = 1'b1;
    end
    check("blank_reached", 32'(ok), 1);
    clr = 1'b1; en = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    check("clrblank_den",    32'(digit_en), 0);
    check("clrblank_busy",   32'(busy), 0);
    check("clrblank_sel",    32'(digit_sel), 0);
    check("clrblank_ready",  32'(cfg_if.cfg_ready), 1);
    check("clrblank_period", 32'(dut.period_q), 50000);
    check("clrblank_blank",  32'(dut.blank_q), 16);

    // Zero period behaves as one cycle
    cfg_idle(0, 2);
    en = 1'b1;
    q_den  = '{1,0,0,2,0,0,4};
    q_tick = '{1,0,0,1,0,0,1};
    trace("p0", q_den, q_tick);
    en = 1'b0;
    @(negedge clk);

`ifdef SCAN_MASK_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cfg_idle(2, 0);
    mask = 4'b0101;
    en = 1'b1;
    q_den  = '{1,1,4,4,1,1};
    q_tick = '{1,0,1,0,1,0};
    trace("mask", q_den, q_tick);
    mask = 4'b0000;
    @(negedge clk);
    check("mask0_den",  32'(digit_en), 0);
    check("mask0_busy", 32'(busy), 0);
    mask = '1;
    en = 1'b0;
    @(negedge clk);
`endif

    // Randomized traffic against the model
    en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      clr = ($urandom_range(0, 499) == 0);
      if (clr) en = 1'b0;
      else if ($urandom_range(0, 39) == 0) en = !en;
      cfg_if.cfg_valid  = ($urandom_range(0, 5) == 0);
      cfg_if.cfg_period = PW'($urandom_range(0, 6));
      cfg_if.cfg_blank  = BW'($urandom_range(0, 3));
`ifdef SCAN_MASK_EN
      if ($urandom_range(0, 49) == 0) mask = NDIG'($urandom_range(0, 15));
`endif
    end
    clr = 1'b0; en = 1'b0; cfg_if.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
